taxi_axis_gmii_rx: RTL and testbench

GMII/MII frame receiver. Takes the PHY-side byte stream or nibble stream and detects the preamble and SFD. It checks the FCS (CRC-32), strips preamble, SFD and FCS, and emits the frame as an AXI4-Stream of bytes. It is the receive-path counterpart of the GMII frame transmitter and sits between the PHY interface logic and the MAC receive FIFO.

---
 rtl/taxi_axis_gmii_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_taxi_axis_gmii_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_axis_gmii_rx.sv
// GMII/MII receive framer: finds preamble/SFD, strips it and the FCS, checks CRC-32,
// and streams the payload as AXI4-Stream bytes with a bad-frame flag on the last beat.
module taxi_axis_gmii_rx #(
  parameter int DATA_W = 8,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] gmii_rxd,
  input  logic              gmii_rx_dv,
  input  logic              gmii_rx_er,
  output logic [DATA_W-1:0] m_axis_rx_tdata,
  output logic              m_axis_rx_tkeep,
  output logic              m_axis_rx_tvalid,
  input  logic              m_axis_rx_tready,
  output logic              m_axis_rx_tlast,
  output logic [USER_W-1:0] m_axis_rx_tuser,
  input  logic              clk_enable,
  input  logic              mii_select,
  input  logic              cfg_rx_enable,
  output logic              start_packet,
  output logic              error_bad_frame,
  output logic              error_bad_fcs
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = {1'b0, c[31:1]} ^ 32'hEDB88320;
      else      c = {1'b0, c[31:1]};
    end
    return c;
  endfunction

  state_t            state_r, state_nxt;
  logic [DATA_W-1:0] rxd_r;
  logic              dv_r, er_r;
  logic [3:0]        nib_d_r;
  logic              dv_d_r;
  logic [3:0][7:0]   dl_r, dl_nxt;
  logic [31:0]       crc_r, crc_nxt;
  logic [2:0]        cnt_r, cnt_nxt;
  logic [7:0]        pend_r, pend_nxt;
  logic              pend_vld_r, pend_vld_nxt;
  logic              sticky_r, sticky_nxt;
  logic              phase_r, phase_nxt;

  logic [7:0]        byte_s;
  logic              byte_en_s;
  logic [31:0]       fcs_rx_s;
  logic              fcs_bad_s;
  logic              emit_s, last_s, bad_s, sop_s, err_frame_s, err_fcs_s;
  logic [USER_W-1:0] user_s;
  logic              unused_tready;

  assign unused_tready   = m_axis_rx_tready;
  assign m_axis_rx_tkeep = 1'b1;
  assign fcs_rx_s        = {dl_r[0], dl_r[1], dl_r[2], dl_r[3]};
  assign fcs_bad_s       = (fcs_rx_s != ~crc_r);

  // Byte assembly; in MII idle every nibble pair is tried so the SFD realigns the phase
  always_comb begin
    byte_s    = rxd_r[7:0];
    byte_en_s = 1'b1;
    if (mii_select) begin
      byte_s = {rxd_r[3:0], nib_d_r};
      if (state_r == ST_PAYLOAD) byte_en_s = phase_r;
      else                       byte_en_s = dv_d_r;
    end else begin
      byte_en_s = 1'b1;
    end
  end

  // Next-state, delay line, CRC and output decode
  always_comb begin
    state_nxt    = state_r;
    dl_nxt       = dl_r;
    crc_nxt      = crc_r;
    cnt_nxt      = cnt_r;
    pend_nxt     = pend_r;
    pend_vld_nxt = pend_vld_r;
    sticky_nxt   = sticky_r;
    phase_nxt    = phase_r;
    emit_s       = 1'b0;
    last_s       = 1'b0;
    bad_s        = 1'b0;
    sop_s        = 1'b0;
    err_frame_s  = 1'b0;
    err_fcs_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!dv_r) begin
          state_nxt = ST_IDLE;
        end else if (!cfg_rx_enable) begin
          state_nxt = ST_DROP;
        end else if (!byte_en_s) begin
          state_nxt = ST_IDLE;
        end else if (byte_s == 8'hD5) begin
          sop_s        = 1'b1;
          crc_nxt      = 32'hFFFFFFFF;
          cnt_nxt      = 3'd0;
          pend_vld_nxt = 1'b0;
          sticky_nxt   = 1'b0;
          phase_nxt    = 1'b0;
          state_nxt    = ST_PAYLOAD;
        end else if (byte_s != 8'h55) begin
          state_nxt = ST_DROP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (!dv_r) begin
          state_nxt = ST_IDLE;
          if (pend_vld_r) begin
            emit_s      = 1'b1;
            last_s      = 1'b1;
            bad_s       = sticky_r | fcs_bad_s;
            err_fcs_s   = fcs_bad_s;
            err_frame_s = sticky_r;
          end else begin
            err_frame_s = 1'b1;
          end
        end else begin
          if (er_r) sticky_nxt = 1'b1;
          else      sticky_nxt = sticky_r;
          phase_nxt = ~phase_r;
          if (byte_en_s) begin
            dl_nxt = {dl_r[2:0], byte_s};
            // Oldest held byte is known payload once four newer bytes exist
            if (cnt_r == 3'd4) begin
              emit_s       = pend_vld_r;
              pend_nxt     = dl_r[3];
              pend_vld_nxt = 1'b1;
              crc_nxt      = crc32_byte(crc_r, dl_r[3]);
            end else begin
              cnt_nxt = cnt_r + 3'd1;
            end
          end else begin
            dl_nxt = dl_r;
          end
        end
      end
      ST_DROP: begin
        if (!dv_r) state_nxt = ST_IDLE;
        else       state_nxt = ST_DROP;
      end
      default: state_nxt = ST_DROP;
    endcase
    user_s    = '0;
    user_s[0] = bad_s;
  end

  // Input sample stage and framing state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_DROP;
      rxd_r      <= '0;
      dv_r       <= 1'b0;
      er_r       <= 1'b0;
      nib_d_r    <= 4'h0;
      dv_d_r     <= 1'b0;
      dl_r       <= '0;
      crc_r      <= 32'hFFFFFFFF;
      cnt_r      <= 3'd0;
      pend_r     <= 8'h00;
      pend_vld_r <= 1'b0;
      sticky_r   <= 1'b0;
      phase_r    <= 1'b0;
    end else if (clk_enable) begin
      state_r    <= state_nxt;
      rxd_r      <= gmii_rxd;
      dv_r       <= gmii_rx_dv;
      er_r       <= gmii_rx_er;
      nib_d_r    <= rxd_r[3:0];
      dv_d_r     <= dv_r;
      dl_r       <= dl_nxt;
      crc_r      <= crc_nxt;
      cnt_r      <= cnt_nxt;
      pend_r     <= pend_nxt;
      pend_vld_r <= pend_vld_nxt;
      sticky_r   <= sticky_nxt;
      phase_r    <= phase_nxt;
    end
  end

  // Registered stream outputs and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_rx_tdata  <= '0;
      m_axis_rx_tvalid <= 1'b0;
      m_axis_rx_tlast  <= 1'b0;
      m_axis_rx_tuser  <= '0;
      start_packet     <= 1'b0;
      error_bad_frame  <= 1'b0;
      error_bad_fcs    <= 1'b0;
    end else if (!clk_enable) begin
      m_axis_rx_tvalid <= 1'b0;
      m_axis_rx_tlast  <= 1'b0;
      m_axis_rx_tuser  <= '0;
      start_packet     <= 1'b0;
      error_bad_frame  <= 1'b0;
      error_bad_fcs    <= 1'b0;
    end else begin
      if (emit_s) m_axis_rx_tdata <= DATA_W'(pend_r);
      m_axis_rx_tvalid <= emit_s;
      m_axis_rx_tlast  <= last_s;
      m_axis_rx_tuser  <= user_s;
      start_packet     <= sop_s;
      error_bad_frame  <= err_frame_s;
      error_bad_fcs    <= err_fcs_s;
    end
  end

endmodule

// File: tb/tb_taxi_axis_gmii_rx.sv
// Directed scoreboard bench for taxi_axis_gmii_rx: GMII/MII frames, FCS/rx_er errors,
// short frames, clock-enable gaps, mid-frame reset and receive disable.
module tb_taxi_axis_gmii_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er;
  logic [7:0] tdata;
  logic       tkeep, tvalid, tready, tlast;
  logic [0:0] tuser;
  logic       clk_enable, mii_select, cfg_rx_enable;
  logic       start_packet, error_bad_frame, error_bad_fcs;

  always #5 clk = ~clk;

  taxi_axis_gmii_rx #(.DATA_W(8), .USER_W(1)) dut (
    .clk(clk), .rst(rst),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep), .m_axis_rx_tvalid(tvalid),
    .m_axis_rx_tready(tready), .m_axis_rx_tlast(tlast), .m_axis_rx_tuser(tuser),
    .clk_enable(clk_enable), .mii_select(mii_select), .cfg_rx_enable(cfg_rx_enable),
    .start_packet(start_packet), .error_bad_frame(error_bad_frame), .error_bad_fcs(error_bad_fcs)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t      obs[$];
  beat_t      exq[$];
  logic [7:0] fr[$];
  int         rd_idx = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         sp_cnt = 0, bf_cnt = 0, bf_last_cnt = 0, fcs_cnt = 0, fcs_last_cnt = 0, tv_cnt = 0;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (tvalid === 1'b1) begin
      obs.push_back('{data: tdata, last: tlast, user: tuser[0]});
      tv_cnt++;
    end
    if (start_packet === 1'b1) sp_cnt++;
    if (error_bad_frame === 1'b1) begin
      bf_cnt++;
      if (tvalid === 1'b1 && tlast === 1'b1) bf_last_cnt++;
    end
    if (error_bad_fcs === 1'b1) begin
      fcs_cnt++;
      if (tvalid === 1'b1 && tlast === 1'b1) fcs_last_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic        fb;
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h00000000);
    end
    return r;
  endfunction

  task automatic drive(input logic [7:0] d, input logic dv, input logic er, input int gap);
    @(posedge clk); #1;
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    clk_enable = 1'b1;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      clk_enable = 1'b0;
      gmii_rxd   = 8'($urandom);
      gmii_rx_dv = 1'($urandom);
      gmii_rx_er = 1'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er, input bit mii, input int gap);
    logic [3:0] junk;
    if (mii) begin
      junk = 4'($urandom);
      drive({junk, b[3:0]}, 1'b1, er, gap);
      junk = 4'($urandom);
      drive({junk, b[7:4]}, 1'b1, 1'b0, gap);
    end else begin
      drive(b, 1'b1, er, gap);
    end
  endtask

  task automatic send_ifg(input int gap);
    for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, (i == 0), gap);
    @(posedge clk); #1;
    clk_enable = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // Preamble, SFD, payload 0..n-1 and optional little-endian FCS
  task automatic build(input int n, input bit fcs_en, input bit fcs_bad);
    logic [31:0] c;
    logic [31:0] f;
    fr.delete();
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      fr.push_back(8'(i));
      c = crc_step(c, 8'(i));
    end
    f = ~c;
    if (fcs_bad) f[24] = ~f[24];
    if (fcs_en) begin
      fr.push_back(f[7:0]);
      fr.push_back(f[15:8]);
      fr.push_back(f[23:16]);
      fr.push_back(f[31:24]);
    end
  endtask

  task automatic run_frame(input string tag, input int n, input bit fcs_en, input bit fcs_bad,
                           input int er_idx, input bit mii, input int gap, input bit out_en,
                           input int exp_sp, input int exp_bf, input int exp_fcs);
    int s_sp, s_bf, s_bfl, s_fcs, s_fcsl, nobs, nmin;
    beat_t o, e;
    @(posedge clk); #1;
    mii_select = mii;
    s_sp = sp_cnt; s_bf = bf_cnt; s_bfl = bf_last_cnt; s_fcs = fcs_cnt; s_fcsl = fcs_last_cnt;
    exq.delete();
    build(n, fcs_en, fcs_bad);
    if (out_en && fcs_en) begin
      for (int i = 0; i < n; i++)
        exq.push_back('{data: 8'(i), last: (i == n - 1), user: (i == n - 1) && (er_idx >= 0 || fcs_bad)});
    end
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i], (i - 8) == er_idx, mii, gap);
    send_ifg(gap);
    nobs = obs.size() - rd_idx;
    chk({tag, " beat_count"}, 32'(nobs), 32'(exq.size()));
    nmin = (nobs < exq.size()) ? nobs : exq.size();
    for (int i = 0; i < nmin; i++) begin
      o = obs[rd_idx + i];
      e = exq[i];
      chk({tag, " data"}, 32'(o.data), 32'(e.data));
      chk({tag, " last"}, 32'(o.last), 32'(e.last));
      chk({tag, " user"}, 32'(o.user), 32'(e.user));
    end
    rd_idx = obs.size();
    chk({tag, " start_packet"}, 32'(sp_cnt - s_sp), 32'(exp_sp));
    chk({tag, " bad_frame"}, 32'(bf_cnt - s_bf), 32'(exp_bf));
    chk({tag, " bad_frame_at_last"}, 32'(bf_last_cnt - s_bfl), 32'((out_en && fcs_en && n > 0) ? exp_bf : 0));
    chk({tag, " bad_fcs"}, 32'(fcs_cnt - s_fcs), 32'(exp_fcs));
    chk({tag, " bad_fcs_at_last"}, 32'(fcs_last_cnt - s_fcsl), 32'(exp_fcs));
  endtask

  initial begin
    logic [31:0] c;
    int s_bf, s_fcs, tv0, nlast;
    rst = 1'b1; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
    clk_enable = 1'b1; mii_select = 1'b0; cfg_rx_enable = 1'b1; tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tvalid", 32'(tvalid), 32'd0);
    chk("reset tlast", 32'(tlast), 32'd0);
    chk("reset tuser", 32'(tuser), 32'd0);
    chk("reset tdata", 32'(tdata), 32'd0);
    chk("reset tkeep", 32'(tkeep), 32'd1);
    chk("reset start_packet", 32'(start_packet), 32'd0);
    chk("reset bad_frame", 32'(error_bad_frame), 32'd0);
    chk("reset bad_fcs", 32'(error_bad_fcs), 32'd0);
    rst = 1'b0;

    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_step(c, 8'h31 + 8'(i));
    chk("crc_model check", ~c, 32'hCBF43926);

    run_frame("gmii_good",   60, 1'b1, 1'b0, -1, 1'b0, 0, 1'b1, 1, 0, 0);
    run_frame("gmii_bad_fcs", 60, 1'b1, 1'b1, -1, 1'b0, 0, 1'b1, 1, 0, 1);
    run_frame("gmii_rx_er",  64, 1'b1, 1'b0, 20, 1'b0, 0, 1'b1, 1, 1, 0);
    run_frame("mii_good",    60, 1'b1, 1'b0, -1, 1'b1, 0, 1'b1, 1, 0, 0);
    run_frame("gmii_ce",     60, 1'b1, 1'b0, -1, 1'b0, 9, 1'b1, 1, 0, 0);
    run_frame("mii_ce",      60, 1'b1, 1'b0, -1, 1'b1, 9, 1'b1, 1, 0, 0);
    run_frame("short",        3, 1'b0, 1'b0, -1, 1'b0, 0, 1'b1, 1, 1, 0);

    // Reset while the frame is still arriving
    mii_select = 1'b0;
    s_bf = bf_cnt; s_fcs = fcs_cnt;
    build(64, 1'b1, 1'b0);
    for (int i = 0; i < 8 + 31; i++) send_byte(fr[i], 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid tvalid", 32'(tvalid), 32'd0);
    chk("rst_mid tlast", 32'(tlast), 32'd0);
    rst = 1'b0;
    tv0 = tv_cnt;
    for (int i = 8 + 31; i < fr.size(); i++) send_byte(fr[i], 1'b0, 1'b0, 0);
    send_ifg(0);
    chk("rst_mid beats_after_reset", 32'(tv_cnt - tv0), 32'd0);
    nlast = 0;
    for (int i = rd_idx; i < obs.size(); i++) if (obs[i].last) nlast++;
    chk("rst_mid tlast_count", 32'(nlast), 32'd0);
    rd_idx = obs.size();
    chk("rst_mid bad_frame", 32'(bf_cnt - s_bf), 32'd0);
    chk("rst_mid bad_fcs", 32'(fcs_cnt - s_fcs), 32'd0);

    run_frame("after_rst", 64, 1'b1, 1'b0, -1, 1'b0, 0, 1'b1, 1, 0, 0);
    cfg_rx_enable = 1'b0;
    run_frame("rx_disabled", 64, 1'b1, 1'b0, -1, 1'b0, 0, 1'b0, 0, 0, 0);
    cfg_rx_enable = 1'b1;
    run_frame("reenabled", 60, 1'b1, 1'b0, -1, 1'b0, 0, 1'b1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
